dec4x16_d_fault0: RTL and testbench

Registered 4-to-16 one-hot decoder built from two 3-to-8 decoders, with stuck-at-0 fault injection on one selectable output line. It is the fault-model variant of the 4x16 decoder and is used to check that downstream logic and benches detect a dead decoder output. The block has a single clock domain and registers its outputs.

---
 rtl/dec_pkg.sv | 13 +
 rtl/dec_3x8.sv | 17 +
 rtl/dec4x16_d_fault0.sv | 74 +++++++
 tb/tb_dec4x16_d_fault0.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared widths and the elaboration-time range check for the 4x16 decoder.
package dec_pkg;

    localparam int SEL_W     = 4;
    localparam int OUT_W     = 16;
    localparam int SUB_SEL_W = 3;
    localparam int SUB_OUT_W = 8;

    function automatic bit fault_line_ok(input int line);
        return (line >= 0) && (line < OUT_W);
    endfunction

endpackage

// File: rtl/dec_3x8.sv
// Combinational 3-to-8 one-hot decoder with enable; disabled output is all zeros.
module dec_3x8
    import dec_pkg::*;
(
    input  logic                 en,
    input  logic [SUB_SEL_W-1:0] sel,
    output logic [SUB_OUT_W-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y = SUB_OUT_W'(1) << sel;
        end
    end

endmodule

// File: rtl/dec4x16_d_fault0.sv
// Registered 4-to-16 decoder with a selectable stuck-at-0 output line.
module dec4x16_d_fault0
    import dec_pkg::*;
#(
    parameter int FAULT_LINE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             X,
    input  logic             Y,
    input  logic             Z,
    input  logic             W,
    input  logic             fault_en,
    output logic [OUT_W-1:0] D,
    output logic             fault_hit
);

    if (!fault_line_ok(FAULT_LINE)) begin : g_bad_fault_line
        $error("dec4x16_d_fault0: FAULT_LINE %0d outside 0..%0d", FAULT_LINE, OUT_W - 1);
    end

    localparam logic [SEL_W-1:0] FAULT_IDX  = SEL_W'(FAULT_LINE);
    localparam logic [OUT_W-1:0] FAULT_MASK = OUT_W'(1) << FAULT_IDX;

    logic [SEL_W-1:0]     sel;
    logic                 en_lo;
    logic                 en_hi;
    logic [SUB_OUT_W-1:0] y_lo;
    logic [SUB_OUT_W-1:0] y_hi;
    logic [OUT_W-1:0]     d_d;
    logic [OUT_W-1:0]     d_q;
    logic                 fault_hit_d;
    logic                 fault_hit_q;

    assign sel   = {X, Y, Z, W};
    assign en_lo = ~X;
    assign en_hi = X;

    dec_3x8 u_dec_lo (
        .en  (en_lo),
        .sel (sel[SUB_SEL_W-1:0]),
        .y   (y_lo)
    );

    dec_3x8 u_dec_hi (
        .en  (en_hi),
        .sel (sel[SUB_SEL_W-1:0]),
        .y   (y_hi)
    );

    // The mask only ever clears FAULT_LINE, so a hit is exactly "selected line is the dead one".
    always_comb begin
        d_d         = {y_hi, y_lo};
        fault_hit_d = 1'b0;
        if (fault_en) begin
            d_d         = d_d & ~FAULT_MASK;
            fault_hit_d = (sel == FAULT_IDX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            fault_hit_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            fault_hit_q <= fault_hit_d;
        end
    end

    assign D         = d_q;
    assign fault_hit = fault_hit_q;

endmodule

// File: tb/tb_dec4x16_d_fault0.sv
// Directed bench: two decoder instances (dead line 0 and dead line 12) on shared inputs.
module tb_dec4x16_d_fault0;

    logic        clk;
    logic        rst_n;
    logic        X, Y, Z, W;
    logic        fault_en;
    logic [15:0] d0, d12;
    logic        fh0, fh12;

    int checks   = 0;
    int failures = 0;

    dec4x16_d_fault0 #(.FAULT_LINE(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .W         (W),
        .fault_en  (fault_en),
        .D         (d0),
        .fault_hit (fh0)
    );

    dec4x16_d_fault0 #(.FAULT_LINE(12)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .W         (W),
        .fault_en  (fault_en),
        .D         (d12),
        .fault_hit (fh12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the following rising edge.
    task automatic step(input int idx, input logic fe);
        logic [3:0] s;
        @(negedge clk);
        s = 4'(idx);
        {X, Y, Z, W} = s;
        fault_en = fe;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] expect_val(input int idx, input logic fe, input int line);
        logic [15:0] d;
        d = 16'(1) << idx;
        if (fe && idx == line) return {1'b1, 16'h0000};
        return {1'b0, d};
    endfunction

    initial begin
        rst_n = 1'b0;
        {X, Y, Z, W} = 4'b0000;
        fault_en = 1'b0;

        for (int t = 0; t < 4; t++) begin
            #23;
            check($sformatf("reset_hold0_%0d", t), {fh0, d0}, 17'h0);
            check($sformatf("reset_hold12_%0d", t), {fh12, d12}, 17'h0);
        end
        #8;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release0", {fh0, d0}, {1'b0, 16'h0001});
        check("reset_release12", {fh12, d12}, {1'b0, 16'h0001});

        for (int i = 0; i < 16; i++) begin
            step(i, 1'b0);
            check($sformatf("sweep_nofault0_idx%0d", i), {fh0, d0}, {1'b0, 16'(1) << i});
            check($sformatf("sweep_nofault12_idx%0d", i), {fh12, d12}, {1'b0, 16'(1) << i});
        end

        step(9, 1'b0);
        check("idx9_literal", {fh0, d0}, {1'b0, 16'h0200});

        step(0, 1'b1);
        check("line0_idx0", {fh0, d0}, {1'b1, 16'h0000});
        check("line12_idx0", {fh12, d12}, {1'b0, 16'h0001});
        step(5, 1'b1);
        check("line0_idx5", {fh0, d0}, {1'b0, 16'h0020});

        for (int i = 0; i < 16; i++) begin
            step(i, 1'b1);
            check($sformatf("sweep_fault12_idx%0d", i), {fh12, d12}, expect_val(i, 1'b1, 12));
            check($sformatf("sweep_fault0_idx%0d", i), {fh0, d0}, expect_val(i, 1'b1, 0));
        end

        step(12, 1'b0);
        check("toggle_off_a", {fh12, d12}, {1'b0, 16'h1000});
        step(12, 1'b1);
        check("toggle_on", {fh12, d12}, {1'b1, 16'h0000});
        step(12, 1'b0);
        check("toggle_off_b", {fh12, d12}, {1'b0, 16'h1000});

        // Select and fault_en changing together at one edge.
        step(0, 1'b1);
        check("joint_change0", {fh0, d0}, {1'b1, 16'h0000});
        step(12, 1'b0);
        check("joint_change12", {fh12, d12}, {1'b0, 16'h1000});

        step(15, 1'b0);
        check("pre_reset_8000", {fh0, d0}, {1'b0, 16'h8000});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset0", {fh0, d0}, 17'h0);
        check("async_reset12", {fh12, d12}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(12, 1'b1);
        check("pre_reset_hit", {fh12, d12}, {1'b1, 16'h0000});
        check("pre_reset_hit_line0", {fh0, d0}, {1'b0, 16'h1000});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_hit12", {fh12, d12}, 17'h0);
        check("async_reset_hit0", {fh0, d0}, 17'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
